mem_copy_master: RTL and testbench
==================================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter ADRS_W, default 13, the BRAM word-address width.
REQ-002 SHALL have parameter LEN_W, default 16, the byte-count width.
REQ-003 SHALL have port clk_ram  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port src_adrs  in  32  source byte address.
REQ-007 SHALL have port dst_adrs  in  32  destination byte address.
REQ-008 SHALL have port len  in  LEN_W  byte count.
REQ-009 SHALL have port busy  out  1  transfer in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port remaining  out  LEN_W  bytes not yet written.
REQ-012 SHALL have port mem_adrs  out  ADRS_W  BRAM port word address.
REQ-013 SHALL have port mem_byteena  out  4  byte enables.
REQ-014 SHALL have port mem_data  out  32  write data.
REQ-015 SHALL have port mem_wren  out  1  write strobe.
REQ-016 SHALL have port mem_q  in  32  read data, valid exactly one cycle after mem_adrs is presented.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR; forward copy only, with no overlap handling.
REQ-018 IDLE: start=1 with len!=0 SHALL latch src, dst and len, then enter RD next cycle with busy=1.
REQ-019 IDLE: start=1 with len==0 SHALL pulse done next cycle with no memory access, and busy SHALL stay 0.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 RD SHALL drive mem_adrs=src[ADRS_W+1:2], mem_wren=0, mem_byteena=4'b1111, mem_data=0, then go to WR.
REQ-022 WR byte unit SHALL select lane s=src[1:0] of mem_q (bits 8s+7:8s), replicate it on all four lanes of mem_data, drive mem_byteena=1<<dst[1:0], mem_adrs=dst word and mem_wren=1.
REQ-023 After each unit, src, dst and remaining SHALL advance by the unit size (1, or 4 for a word unit), with addresses wrapping modulo 2^(ADRS_W+2).
REQ-024 WR SHALL return to RD if remaining after the unit is nonzero, else to IDLE, with done=1 and busy=0 in the following cycle.
REQ-025 Each unit SHALL take exactly 2 cycles (RD, WR).
REQ-026 start presented in the done cycle SHALL be accepted.
REQ-027 In IDLE, mem_wren SHALL be 0, mem_byteena SHALL be 4'b1111, and mem_adrs and mem_data SHALL be 0.

Reset
REQ-028 reset SHALL force IDLE with busy=0, done=0, remaining=0, mem_wren=0 and mem_adrs=0, mem_byteena=4'b1111, mem_data=0, with precedence over start.
REQ-029 reset asserted mid-transfer SHALL abort in that cycle, with no further writes and no done pulse.

Configuration
REQ-030 Macro MEMCPY_WORD_FAST_EN defined: WR SHALL move a word unit (mem_data=mem_q, mem_byteena=4'b1111, advance 4) when src[1:0]==0, dst[1:0]==0 and remaining>=4; otherwise it SHALL move a byte unit.
REQ-031 Macro MEMCPY_WORD_FAST_EN undefined: every unit SHALL be a byte unit.

Verification
REQ-032 src=0x100, dst=0x200, len=8, macro on -> two word writes to word addresses 0x80 and 0x81, byteena 1111; done 5 cycles after start.
REQ-033 Same stimulus, macro off -> 8 byte writes with byteena 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; done 17 cycles after start.
REQ-034 src=0x101, dst=0x203, len=3, mem[0x100]=0xDDCCBBAA -> writes of 0xBB (byteena 1000 at word 0x80), then 0xCC and 0xDD at word 0x81 with byteena 0001 and 0010; remaining counts 3, 2, 1, 0.
REQ-035 len=0 -> done one cycle after start, mem_wren never 1, busy never 1.
REQ-036 reset during the 2nd WR of an 8-byte transfer -> busy=0 and mem_wren=0 next cycle, no done pulse; a later start with len=4 completes normally.

Source files
------------

// File: rtl/mem_copy_master.sv
// Byte/word memory-to-memory copy engine driving a single BRAM port (1-cycle read latency).
// Define MEMCPY_WORD_FAST_EN to move aligned 4-byte words in one unit instead of single bytes.
module mem_copy_master #(
  parameter int unsigned ADRS_W = 13,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_ram,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       src_adrs,
  input  logic [31:0]       dst_adrs,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  localparam int unsigned BA_W = ADRS_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

  state_e            state_q;
  logic [BA_W-1:0]   src_q;
  logic [BA_W-1:0]   dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic              word_q;
  logic [ADRS_W-1:0] mem_adrs_q;
  logic [3:0]        mem_byteena_q;
  logic              mem_wren_q;

  logic              word_unit_c;
  logic [BA_W-1:0]   step_c;
  logic [BA_W-1:0]   src_nxt_c;
  logic [BA_W-1:0]   dst_nxt_c;
  logic [LEN_W-1:0]  rem_nxt_c;
  logic [31:0]       mem_data_c;

  // Address bits above the BRAM byte space are intentionally discarded.
  logic unused_adrs_c;
  assign unused_adrs_c = ^{src_adrs[31:BA_W], dst_adrs[31:BA_W]};

`ifdef MEMCPY_WORD_FAST_EN
  assign word_unit_c = (src_q[1:0] == 2'b00) && (dst_q[1:0] == 2'b00) && (rem_q >= LEN_W'(4));
`else
  assign word_unit_c = 1'b0;
`endif

  assign step_c    = word_q ? BA_W'(4) : BA_W'(1);
  assign src_nxt_c = src_q + step_c;
  assign dst_nxt_c = dst_q + step_c;
  assign rem_nxt_c = rem_q - (word_q ? LEN_W'(4) : LEN_W'(1));

  // Write data must come straight from mem_q: it only becomes valid in the WR cycle itself.
  always_comb begin
    mem_data_c = '0;
    if (state_q == S_WR) begin
      mem_data_c = word_q ? mem_q : {4{mem_q[{src_q[1:0], 3'b000} +: 8]}};
    end
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      state_q       <= S_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      word_q        <= 1'b0;
      mem_adrs_q    <= '0;
      mem_byteena_q <= 4'b1111;
      mem_wren_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q        <= 1'b0;
          mem_adrs_q    <= '0;
          mem_byteena_q <= 4'b1111;
          mem_wren_q    <= 1'b0;
          if (start) begin
            if (len != '0) begin
              src_q      <= src_adrs[BA_W-1:0];
              dst_q      <= dst_adrs[BA_W-1:0];
              rem_q      <= len;
              busy_q     <= 1'b1;
              mem_adrs_q <= src_adrs[BA_W-1:2];
              state_q    <= S_RD;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_RD: begin
          word_q        <= word_unit_c;
          mem_adrs_q    <= dst_q[BA_W-1:2];
          mem_byteena_q <= word_unit_c ? 4'b1111 : (4'b0001 << dst_q[1:0]);
          mem_wren_q    <= 1'b1;
          state_q       <= S_WR;
        end
        S_WR: begin
          src_q         <= src_nxt_c;
          dst_q         <= dst_nxt_c;
          rem_q         <= rem_nxt_c;
          mem_byteena_q <= 4'b1111;
          mem_wren_q    <= 1'b0;
          if (rem_nxt_c != '0) begin
            mem_adrs_q <= src_nxt_c[BA_W-1:2];
            state_q    <= S_RD;
          end else begin
            mem_adrs_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign remaining   = rem_q;
  assign mem_adrs    = mem_adrs_q;
  assign mem_byteena = mem_byteena_q;
  assign mem_wren    = mem_wren_q;
  assign mem_data    = mem_data_c;

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: a byte-level copy model predicts every write and done pulse.
module tb_mem_copy_master;

  localparam int unsigned AW = 13;
  localparam int unsigned LW = 16;
  localparam int unsigned NWORDS = 1 << AW;

`ifdef MEMCPY_WORD_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk_ram;
  logic          reset;
  logic          start;
  logic [31:0]   src_adrs;
  logic [31:0]   dst_adrs;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [LW-1:0] remaining;
  logic [AW-1:0] mem_adrs;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data;
  logic          mem_wren;
  logic [31:0]   mem_q;

  mem_copy_master #(.ADRS_W(AW), .LEN_W(LW)) dut (
    .clk_ram     (clk_ram),
    .reset       (reset),
    .start       (start),
    .src_adrs    (src_adrs),
    .dst_adrs    (dst_adrs),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .remaining   (remaining),
    .mem_adrs    (mem_adrs),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial begin
    clk_ram = 1'b0;
    forever #5 clk_ram = ~clk_ram;
  end

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [LW-1:0] rem;
  } wr_t;

  wr_t   wq[$];
  int    dq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  bit    armed = 1'b0;
  bit    mem_ready = 1'b0;
  logic [AW-1:0] last_rd = '0;

  logic [31:0] mem     [NWORDS];
  logic [31:0] ref_mem [NWORDS];

  always @(posedge clk_ram) cyc = cyc + 1;

  // BRAM model: registered read, byte-enabled write; preloaded on the first edge.
  always @(posedge clk_ram) begin
    if (!mem_ready) begin
      for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
      mem[13'h040] = 32'hDDCCBBAA;
      mem_ready = 1'b1;
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_adrs][8*b +: 8] = mem_data[8*b +: 8];
    end
    mem_q <= mem[mem_adrs];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference copy: walks the byte stream, choosing word units where alignment allows.
  task automatic model(input logic [31:0] s0, input logic [31:0] d0, input logic [LW-1:0] n,
                       input int maxu, output int u, output bit fin);
    logic [AW+1:0] s, d;
    logic [LW-1:0] r;
    logic [31:0]   rw;
    logic [7:0]    b;
    wr_t           e;
    bit            word;
    s = s0[AW+1:0];
    d = d0[AW+1:0];
    r = n;
    u = 0;
    while (r != 0 && u < maxu) begin
      word = FAST && (s % 4 == 0) && (d % 4 == 0) && (r >= 4);
      rw   = ref_mem[s / 4];
      e.rd  = AW'(s / 4);
      e.wr  = AW'(d / 4);
      e.rem = r;
      if (word) begin
        e.data = rw;
        e.be   = 4'b1111;
        ref_mem[d / 4] = rw;
      end else begin
        b = rw[8 * (s % 4) +: 8];
        e.data = {4{b}};
        e.be   = 4'(1 << (d % 4));
        ref_mem[d / 4][8 * (d % 4) +: 8] = b;
      end
      wq.push_back(e);
      s = s + (word ? 4 : 1);
      d = d + (word ? 4 : 1);
      r = r - LW'(word ? 4 : 1);
      u++;
    end
    fin = (r == 0);
  endtask

  // Issue one transfer; returns in its done cycle so the next start can land there.
  task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] n,
                      input int maxu, input bit poke, input int gap);
    int k, u, p;
    bit fin;
    k = cyc;
    model(s, d, n, maxu, u, fin);
    if (fin) dq.push_back(k + 2 * u + 1);
    src_adrs = s;
    dst_adrs = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk_ram); #1;
    start    = 1'b0;
    src_adrs = $urandom;
    dst_adrs = $urandom;
    len      = LW'($urandom);
    if (!fin) return;
    if (poke && u > 0) begin
      p = k + 1 + $urandom_range(0, 2 * u - 1);
      while (cyc < p) begin @(posedge clk_ram); #1; end
      start = 1'b1;
      @(posedge clk_ram); #1;
      start = 1'b0;
    end
    while (cyc < k + 2 * u + 1) begin @(posedge clk_ram); #1; end
    repeat (gap) begin @(posedge clk_ram); #1; end
  endtask

  // Monitor: pops expected writes / done pulses as the DUT presents them.
  always @(negedge clk_ram) begin
    wr_t e;
    if (armed) begin
      if (mem_wren) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_write: got adrs %h expected no write (cycle %0d)", mem_adrs, cyc);
        end else begin
          e = wq.pop_front();
          chk("rd_adrs",   32'(last_rd),     32'(e.rd));
          chk("wr_adrs",   32'(mem_adrs),    32'(e.wr));
          chk("byteena",   32'(mem_byteena), 32'(e.be));
          chk("wr_data",   mem_data,         e.data);
          chk("remaining", 32'(remaining),   32'(e.rem));
        end
      end else if (busy) begin
        last_rd = mem_adrs;
        chk("rd_byteena", 32'(mem_byteena), 32'hF);
        chk("rd_data",    mem_data,         32'h0);
        chk("busy_expected", 32'(wq.size() != 0), 32'h1);
      end else begin
        chk("idle_adrs",    32'(mem_adrs),    32'h0);
        chk("idle_byteena", 32'(mem_byteena), 32'hF);
        chk("idle_data",    mem_data,         32'h0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
          chk("done_busy",  32'(busy), 32'h0);
          chk("done_remaining", 32'(remaining), 32'h0);
        end
      end
    end
  end

  initial begin
    int k, t, diffs;
    logic [31:0] s, d;
    logic [LW-1:0] n;
    logic [31:0] w;
    reset = 1'b1; start = 1'b0; src_adrs = '0; dst_adrs = '0; len = '0;
    repeat (3) @(posedge clk_ram);
    #1;
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = mem[i];
    chk("rst_busy",      32'(busy),        32'h0);
    chk("rst_done",      32'(done),        32'h0);
    chk("rst_remaining", 32'(remaining),   32'h0);
    chk("rst_wren",      32'(mem_wren),    32'h0);
    chk("rst_adrs",      32'(mem_adrs),    32'h0);
    chk("rst_byteena",   32'(mem_byteena), 32'hF);
    chk("rst_data",      mem_data,         32'h0);
    reset = 1'b0;
    armed = 1'b1;
    @(posedge clk_ram); #1;

    // Unaligned 3-byte copy out of the preloaded word DDCCBBAA.
    xfer(32'h101, 32'h203, 3, 1000, 1'b0, 1);
    w = mem[13'h080]; chk("ex_byte_bb", 32'(w[31:24]), 32'hBB);
    w = mem[13'h081]; chk("ex_byte_cc", 32'(w[7:0]),   32'hCC);
    chk("ex_byte_dd", 32'(w[15:8]), 32'hDD);

    xfer(32'h100, 32'h200, 8, 1000, 1'b0, 2);
    xfer(32'h0,   32'h0,   0, 1000, 1'b0, 0);
    xfer(32'h10,  32'h20,  0, 1000, 1'b0, 0);
    xfer(32'h7FFD, 32'h7FFA, 7, 1000, 1'b1, 0);

    // Abort with reset during the second WR; only two writes may land.
    k = cyc;
    xfer(32'h101, 32'h301, 8, 2, 1'b0, 0);
    while (cyc < k + 4) begin @(posedge clk_ram); #1; end
    reset = 1'b1;
    @(posedge clk_ram); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy),     32'h0);
    chk("abort_wren", 32'(mem_wren), 32'h0);
    chk("abort_pending", 32'(wq.size()), 32'h0);
    repeat (4) begin @(posedge clk_ram); #1; end
    xfer(32'h400, 32'h500, 4, 1000, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      s = $urandom;
      d = $urandom;
      if ($urandom_range(0, 1) == 1) begin s[1:0] = 2'b00; d[1:0] = 2'b00; end
      if (i % 10 == 3) s[14:0] = 15'h7FFC;
      n = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
      xfer(s, d, n, 1000, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    t = 0;
    while ((wq.size() != 0 || dq.size() != 0) && t < 200) begin
      @(posedge clk_ram); t++;
    end
    #1;
    chk("drain", 32'(wq.size() + dq.size()), 32'h0);
    diffs = 0;
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
